// File: rtl/riva_pkg.sv
// Shared types and constants for the RIVA vector load/store request path.
// Holds the page geometry, AXI burst encoding, fragment meta typedefs and
// the tag carried alongside each outstanding transaction.
package riva_pkg;

  // One 4 KiB page expressed in nibbles.
  localparam int unsigned PageNibbles = 8192;
  localparam int unsigned PageNibBits = 13;

  localparam logic [1:0] AxBurstIncr = 2'b01;

  localparam int unsigned ReqIdWidth   = 4;
  localparam int unsigned RmnWidth     = 8;
  localparam int unsigned TxnWidth     = 8;
  // ltN spans 1..8192, so it needs one bit more than the in-page offset.
  localparam int unsigned LtnWidth     = 14;
  // Nibble address for a 64-bit byte address space.
  localparam int unsigned NibAddrWidth = 65;

  typedef enum logic [1:0] {
    ModeUnit    = 2'd0,
    ModeStrided = 2'd1,
    ModeIndexed = 2'd2
  } mode_e;

  typedef struct packed {
    logic [ReqIdWidth-1:0] req_id;
    mode_e                 mode;
    logic                  is_load;
    logic [RmnWidth-1:0]   rmn_grp;
    logic [RmnWidth-1:0]   rmn_seg;
  } meta_glb_t;

  typedef struct packed {
    logic [NibAddrWidth-1:0] seg_base_addr;
    logic [TxnWidth-1:0]     txn_num;
    logic [TxnWidth-1:0]     txn_cnt;
    logic [LtnWidth-1:0]     ltn;
  } meta_seglv_t;

  typedef struct packed {
    logic                  is_final;
    logic [ReqIdWidth-1:0] req_id;
  } tag_t;

  // Last transaction of its segment.
  function automatic logic is_last_txn(meta_seglv_t seg);
    return seg.txn_cnt == seg.txn_num;
  endfunction

  // Last transaction of the whole request: no groups or segments remain.
  function automatic logic is_final_txn(meta_glb_t glb, meta_seglv_t seg);
    return (glb.rmn_grp == '0) && (glb.rmn_seg == '0) && is_last_txn(seg);
  endfunction

endpackage

// File: rtl/vlsu_txn_issuer_if.sv
// Bundle between the fragmenter meta stream, the AXI address channel and the
// response/completion side of vlsu_txn_issuer.
// master: the issuer (drives meta_ready, ax_*, req_done_*, err).
// slave:  the surrounding fabric (drives meta_*, ax_ready, rsp_valid).
interface vlsu_txn_issuer_if #(
  parameter int unsigned AxiAddrWidth = 64
) ();
  import riva_pkg::*;

  logic                    meta_valid;
  logic                    meta_ready;
  meta_glb_t               meta_glb;
  meta_seglv_t             meta_seglv;

  logic                    ax_valid;
  logic                    ax_ready;
  logic [AxiAddrWidth-1:0] ax_addr;
  logic [7:0]              ax_len;
  logic [2:0]              ax_size;
  logic [1:0]              ax_burst;
  logic                    ax_write;

  logic                    rsp_valid;
  logic                    req_done_valid;
  logic [ReqIdWidth-1:0]   req_done_id;
  logic                    err;

  modport master (
    input  meta_valid, meta_glb, meta_seglv, ax_ready, rsp_valid,
    output meta_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst, ax_write,
           req_done_valid, req_done_id, err
  );

  modport slave (
    output meta_valid, meta_glb, meta_seglv, ax_ready, rsp_valid,
    input  meta_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst, ax_write,
           req_done_valid, req_done_id, err
  );

endinterface

// File: rtl/vlsu_tag_fifo.sv
// Synchronous FIFO of outstanding-transaction tags, power-of-two depth.
// Latency: pushed entry visible at head the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty
// reflect the registered count only (no same-cycle bypass).
// Ports: clk_i, rst_ni (sync, active-low), push/push_data, pop, head, full, empty.
module vlsu_tag_fifo #(
  parameter int unsigned Depth  = 8,
  parameter type         elem_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push,
  input  elem_t push_data,
  input  logic  pop,
  output elem_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  elem_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == (PtrW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/vlsu_txn_issuer.sv
// Turns one fragmenter meta beat into one AXI4 INCR address request and
// tracks outstanding transactions to report request completion.
// Latency: meta accepted in cycle N -> ax_valid in N+1; completion pulse one
// cycle after the response that retires a request's final transaction.
// Backpressure: meta_ready drops while the output register is held by
// ax_ready low or while MaxOutstanding transactions are in flight.
// Ports: clk_i, rst_ni (sync, active-low), bus (master modport of
// vlsu_txn_issuer_if: meta stream in, AXI address channel out, rsp_valid in,
// req_done/err out).
module vlsu_txn_issuer
  import riva_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 128,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  vlsu_txn_issuer_if.master  bus
);

  // One extra bit so the exclusive end of the topmost page is representable.
  localparam int unsigned CalcW     = AxiAddrWidth + 1;
  localparam int unsigned BeatShift = $clog2(AxiDataWidth / 8);
  localparam logic [2:0]  AxSize    = 3'(BeatShift);

  // A 4 KiB page must fit in 256 beats so ax_len never overflows.
  if (AxiDataWidth < 128) begin : g_check_data_width
    $error("AxiDataWidth must be at least 128");
  end
  if ((MaxOutstanding < 2) || ((MaxOutstanding & (MaxOutstanding - 1)) != 0)) begin : g_check_depth
    $error("MaxOutstanding must be a power of two, at least 2");
  end

  typedef enum logic {
    IssueEmpty  = 1'b0,
    IssueLoaded = 1'b1
  } issue_state_e;

  issue_state_e            state_q, state_d;
  logic                    meta_ready;
  logic                    accept;

  logic [AxiAddrWidth-1:0] ax_addr_q;
  logic [7:0]              ax_len_q;
  logic                    ax_write_q;
  logic [AxiAddrWidth-1:0] ax_addr_d;
  logic [7:0]              ax_len_d;

  logic                    tag_full;
  logic                    tag_empty;
  tag_t                    tag_in;
  tag_t                    tag_head;
  logic                    pop_ok;

  logic                    done_valid_q;
  logic [ReqIdWidth-1:0]   done_id_q;
  logic                    err_q;

  // ---------------------------------------------------------------------------
  // Fragment -> byte address / beat count
  // ---------------------------------------------------------------------------
  logic [CalcW-1:0] base_nib, page_base, start_nib, end_nib;
  logic [CalcW-1:0] byte_start, byte_end, len_full;

  always_comb begin
    base_nib  = CalcW'(bus.meta_seglv.seg_base_addr);
    page_base = base_nib & ~CalcW'(PageNibbles - 1);

    // Only the first transaction of a segment starts mid-page.
    if (bus.meta_seglv.txn_cnt == '0) begin
      start_nib = base_nib;
    end else begin
      start_nib = page_base + (CalcW'(bus.meta_seglv.txn_cnt) << PageNibBits);
    end

    if (is_last_txn(bus.meta_seglv)) begin
      end_nib = page_base + (CalcW'(bus.meta_seglv.txn_num) << PageNibBits)
              + CalcW'(bus.meta_seglv.ltn);
    end else begin
      end_nib = page_base + ((CalcW'(bus.meta_seglv.txn_cnt) + CalcW'(1)) << PageNibBits);
    end

    // A trailing odd nibble still needs its whole byte.
    byte_start = start_nib >> 1;
    byte_end   = (end_nib + CalcW'(1)) >> 1;
    len_full   = ((byte_end - CalcW'(1)) >> BeatShift) - (byte_start >> BeatShift);

    ax_addr_d  = AxiAddrWidth'(byte_start);
    ax_len_d   = 8'(len_full);
  end

  // ---------------------------------------------------------------------------
  // Issue register control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    meta_ready = 1'b0;
    accept     = 1'b0;

    // Full is judged on the registered count; a same-cycle pop does not help.
    meta_ready = ((state_q == IssueEmpty) || bus.ax_ready) && !tag_full;
    accept     = bus.meta_valid && meta_ready;

    case (state_q)
      IssueEmpty:  if (accept) state_d = IssueLoaded;
      IssueLoaded: if (!accept && bus.ax_ready) state_d = IssueEmpty;
      default:     state_d = IssueEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IssueEmpty;
      ax_addr_q  <= '0;
      ax_len_q   <= '0;
      ax_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ax_addr_q  <= ax_addr_d;
        ax_len_q   <= ax_len_d;
        ax_write_q <= !bus.meta_glb.is_load;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-order outstanding tracking and completion
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_in          = '0;
    tag_in.is_final = is_final_txn(bus.meta_glb, bus.meta_seglv);
    tag_in.req_id   = bus.meta_glb.req_id;
  end

  vlsu_tag_fifo #(
    .Depth  (MaxOutstanding),
    .elem_t (tag_t)
  ) i_tag_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept),
    .push_data (tag_in),
    .pop       (bus.rsp_valid),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign pop_ok = bus.rsp_valid && !tag_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      done_valid_q <= pop_ok && tag_head.is_final;
      if (pop_ok && tag_head.is_final) begin
        done_id_q <= tag_head.req_id;
      end
      // A response with nothing outstanding is a protocol error; keep it.
      if (bus.rsp_valid && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.meta_ready     = meta_ready;
  assign bus.ax_valid       = (state_q == IssueLoaded);
  assign bus.ax_addr        = ax_addr_q;
  assign bus.ax_len         = ax_len_q;
  assign bus.ax_size        = AxSize;
  assign bus.ax_burst       = AxBurstIncr;
  assign bus.ax_write       = ax_write_q;
  assign bus.req_done_valid = done_valid_q;
  assign bus.req_done_id    = done_id_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_vlsu_txn_issuer.sv
// Bench for vlsu_txn_issuer: table of single-transaction vectors, directed
// multi-cycle sequences (backpressure, outstanding limit, completion, reset),
// then randomized traffic against a queue-based reference model.
module tb_vlsu_txn_issuer;
  import riva_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;
  localparam int unsigned MO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vlsu_txn_issuer_if #(.AxiAddrWidth(AW)) bus ();

  vlsu_txn_issuer #(
    .AxiAddrWidth   (AW),
    .AxiDataWidth   (DW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_meta(input logic [3:0] id, input logic ld, input logic [7:0] rg,
                          input logic [7:0] rs, input logic [64:0] base,
                          input logic [7:0] num, input logic [7:0] cnt, input logic [13:0] ltn);
    bus.meta_glb.req_id         = id;
    bus.meta_glb.mode           = ModeUnit;
    bus.meta_glb.is_load        = ld;
    bus.meta_glb.rmn_grp        = rg;
    bus.meta_glb.rmn_seg        = rs;
    bus.meta_seglv.seg_base_addr = base;
    bus.meta_seglv.txn_num      = num;
    bus.meta_seglv.txn_cnt      = cnt;
    bus.meta_seglv.ltn          = ltn;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ax_valid"}, 64'(bus.ax_valid), 64'd0);
    check({tag, "_ax_addr"},  bus.ax_addr, 64'd0);
    check({tag, "_ax_len"},   64'(bus.ax_len), 64'd0);
    check({tag, "_ax_write"}, 64'(bus.ax_write), 64'd0);
    check({tag, "_done"},     64'(bus.req_done_valid), 64'd0);
    check({tag, "_done_id"},  64'(bus.req_done_id), 64'd0);
    check({tag, "_err"},      64'(bus.err), 64'd0);
    check({tag, "_meta_rdy"}, 64'(bus.meta_ready), 64'd1);
    check({tag, "_ax_size"},  64'(bus.ax_size), 64'd4);
    check({tag, "_ax_burst"}, 64'(bus.ax_burst), 64'd1);
  endtask

  // Reference: work from the page index and plain byte/beat division.
  function automatic void model_txn(input logic [64:0] base, input int num, input int cnt,
                                    input int ltn, output logic [63:0] addr, output logic [7:0] len);
    longint unsigned b, page, s, e, first_byte, last_byte;
    b    = base[63:0];
    page = b / 8192;
    s    = (cnt == 0) ? b : (page + longint'(cnt)) * 8192;
    e    = (cnt == num) ? (page + longint'(num)) * 8192 + longint'(ltn)
                        : (page + longint'(cnt) + 1) * 8192;
    first_byte = s / 2;
    last_byte  = (e + 1) / 2 - 1;
    addr = first_byte;
    len  = 8'(last_byte / 16 - first_byte / 16);
  endfunction

  typedef struct {
    logic [64:0] base;
    logic [7:0]  num;
    logic [7:0]  cnt;
    logic [13:0] ltn;
    logic        ld;
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
  } vec_t;
  vec_t vecs [7];

  typedef struct { logic [63:0] addr; logic [7:0] len; logic wr; } ax_exp_t;
  typedef struct { logic fin; logic [3:0] id; } tag_exp_t;
  ax_exp_t  axq [$];
  tag_exp_t tq  [$];

  logic        exp_done;
  logic [3:0]  exp_done_id;
  logic        exp_mr;
  logic [64:0] r_base;
  int          r_num, r_cnt, r_ltn, accepted;
  logic [3:0]  r_id;
  logic        r_ld;
  logic [7:0]  r_rg, r_rs;
  ax_exp_t     ax_new;
  tag_exp_t    t_pop;

  initial begin
    vecs[0] = '{65'h2000,        8'd0, 8'd0, 14'h40,   1'b1, 64'h1000,        8'd1};
    vecs[1] = '{65'h3F80,        8'd1, 8'd0, 14'h1,    1'b1, 64'h1FC0,        8'd3};
    vecs[2] = '{65'h3F80,        8'd1, 8'd1, 14'h80,   1'b1, 64'h2000,        8'd3};
    vecs[3] = '{65'h2001,        8'd0, 8'd0, 14'h4,    1'b1, 64'h1000,        8'd0};
    vecs[4] = '{65'h4000,        8'd0, 8'd0, 14'd8192, 1'b0, 64'h2000,        8'd255};
    vecs[5] = '{65'h2003,        8'd0, 8'd0, 14'h22,   1'b0, 64'h1001,        8'd1};
    vecs[6] = '{65'hA_BCDE_1F00, 8'd2, 8'd1, 14'h10,   1'b0, 64'h5_5E6F_1000, 8'd255};

    rst_n = 1'b0;
    bus.meta_valid = 1'b0;
    bus.ax_ready   = 1'b0;
    bus.rsp_valid  = 1'b0;
    set_meta(4'd0, 1'b1, 8'd0, 8'd0, 65'd0, 8'd0, 8'd0, 14'd1);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // ---- table vectors -------------------------------------------------
    bus.ax_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set_meta(4'(i), vecs[i].ld, 8'd1, 8'd0, vecs[i].base, vecs[i].num, vecs[i].cnt, vecs[i].ltn);
      bus.meta_valid = 1'b1;
      #1 check($sformatf("vec%0d_meta_rdy", i), 64'(bus.meta_ready), 64'd1);
      @(negedge clk);
      bus.meta_valid = 1'b0;
      check($sformatf("vec%0d_ax_valid", i), 64'(bus.ax_valid), 64'd1);
      check($sformatf("vec%0d_addr", i), bus.ax_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_len", i), 64'(bus.ax_len), 64'(vecs[i].exp_len));
      check($sformatf("vec%0d_write", i), 64'(bus.ax_write), 64'(!vecs[i].ld));
      bus.rsp_valid = 1'b1;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      check($sformatf("vec%0d_ax_idle", i), 64'(bus.ax_valid), 64'd0);
    end

    // ---- backpressure --------------------------------------------------
    @(negedge clk);
    bus.ax_ready = 1'b0;
    set_meta(4'd1, 1'b1, 8'd1, 8'd0, vecs[0].base, 8'd0, 8'd0, vecs[0].ltn);
    bus.meta_valid = 1'b1;
    #1 check("bp_first_rdy", 64'(bus.meta_ready), 64'd1);
    @(negedge clk);
    set_meta(4'd2, 1'b0, 8'd1, 8'd0, vecs[5].base, 8'd0, 8'd0, vecs[5].ltn);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_valid", c), 64'(bus.ax_valid), 64'd1);
      check($sformatf("bp%0d_addr", c), bus.ax_addr, 64'h1000);
      check($sformatf("bp%0d_len", c), 64'(bus.ax_len), 64'd1);
      check($sformatf("bp%0d_write", c), 64'(bus.ax_write), 64'd0);
      check($sformatf("bp%0d_meta_rdy", c), 64'(bus.meta_ready), 64'd0);
      @(negedge clk);
    end
    bus.ax_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(bus.meta_ready), 64'd1);
    @(negedge clk);
    bus.meta_valid = 1'b0;
    check("bp_next_valid", 64'(bus.ax_valid), 64'd1);
    check("bp_next_addr", bus.ax_addr, 64'h1001);
    check("bp_next_write", 64'(bus.ax_write), 64'd1);
    @(negedge clk);
    check("bp_drained", 64'(bus.ax_valid), 64'd0);
    bus.rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.rsp_valid = 1'b0;

    // ---- outstanding limit ---------------------------------------------
    for (int k = 0; k < 4; k++) begin
      set_meta(4'(k), 1'b1, 8'd1, 8'd0, vecs[0].base, 8'd0, 8'd0, vecs[0].ltn);
      bus.meta_valid = 1'b1;
      #1 check($sformatf("lim%0d_rdy", k), 64'(bus.meta_ready), 64'd1);
      @(negedge clk);
    end
    #1 check("lim_full_rdy", 64'(bus.meta_ready), 64'd0);
    @(negedge clk);
    bus.meta_valid = 1'b0;
    bus.rsp_valid  = 1'b1;
    #1 check("lim_no_bypass", 64'(bus.meta_ready), 64'd0);
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    #1 check("lim_after_pop", 64'(bus.meta_ready), 64'd1);
    bus.rsp_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rsp_valid = 1'b0;
    check("lim_err_clean", 64'(bus.err), 64'd0);

    // ---- completion: request 5 in three fragments ----------------------
    for (int f = 0; f < 3; f++) begin
      if (f == 0) set_meta(4'd5, 1'b1, 8'd0, 8'd1, 65'h2000, 8'd0, 8'd0, 14'h40);
      else        set_meta(4'd5, 1'b1, 8'd0, 8'd0, 65'h3F80, 8'd1, 8'(f - 1), 14'h80);
      bus.meta_valid = 1'b1;
      @(negedge clk);
    end
    bus.meta_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus.rsp_valid = 1'b1;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      check($sformatf("cmp_done%0d", r), 64'(bus.req_done_valid), 64'(r == 2));
      if (r == 2) check("cmp_done_id", 64'(bus.req_done_id), 64'd5);
    end
    @(negedge clk);
    check("cmp_single_pulse", 64'(bus.req_done_valid), 64'd0);

    // ---- reset in the middle of request 6 -------------------------------
    for (int f = 0; f < 3; f++) begin
      if (f == 0) set_meta(4'd6, 1'b1, 8'd0, 8'd1, 65'h2000, 8'd0, 8'd0, 14'h40);
      else        set_meta(4'd6, 1'b1, 8'd0, 8'd0, 65'h3F80, 8'd1, 8'(f - 1), 14'h80);
      bus.meta_valid = 1'b1;
      @(negedge clk);
    end
    bus.meta_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.rsp_valid = 1'b1;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      check($sformatf("mid_done%0d", r), 64'(bus.req_done_valid), 64'd0);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    // The final tag was discarded, so this response finds the FIFO empty.
    bus.rsp_valid = 1'b1;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    check("midrst_no_pulse", 64'(bus.req_done_valid), 64'd0);
    check("err_set", 64'(bus.err), 64'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(bus.err), 64'd1);
    check("err_no_pulse", 64'(bus.req_done_valid), 64'd0);

    // ---- randomized traffic against the reference model ----------------
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_done    = 1'b0;
    exp_done_id = 4'd0;
    accepted    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      r_id   = 4'($urandom_range(0, 15));
      r_ld   = 1'($urandom_range(0, 1));
      r_rg   = 8'($urandom_range(0, 1));
      r_rs   = 8'($urandom_range(0, 1));
      r_num  = $urandom_range(0, 3);
      r_cnt  = $urandom_range(0, r_num);
      r_base = {25'd0, 8'($urandom_range(0, 255)), 32'($urandom)};
      if (r_num == 0) r_ltn = $urandom_range(int'(r_base[12:0]) + 1, 8192);
      else            r_ltn = $urandom_range(1, 8192);
      set_meta(r_id, r_ld, r_rg, r_rs, r_base, 8'(r_num), 8'(r_cnt), 14'(r_ltn));
      bus.meta_valid = (accepted < 500) && ($urandom_range(0, 3) != 0);
      bus.ax_ready   = ($urandom_range(0, 2) != 0);
      bus.rsp_valid  = (tq.size() != 0) && ($urandom_range(0, 2) == 0);
      #1;
      exp_mr = ((axq.size() == 0) || bus.ax_ready) && (tq.size() < MO);
      check("rnd_ax_valid", 64'(bus.ax_valid), 64'(axq.size() != 0));
      if (axq.size() != 0) begin
        check("rnd_addr", bus.ax_addr, axq[0].addr);
        check("rnd_len", 64'(bus.ax_len), 64'(axq[0].len));
        check("rnd_write", 64'(bus.ax_write), 64'(axq[0].wr));
      end
      check("rnd_meta_rdy", 64'(bus.meta_ready), 64'(exp_mr));
      check("rnd_done", 64'(bus.req_done_valid), 64'(exp_done));
      if (exp_done) check("rnd_done_id", 64'(bus.req_done_id), 64'(exp_done_id));
      check("rnd_err", 64'(bus.err), 64'd0);

      // Advance the model across the coming rising edge.
      if ((axq.size() != 0) && bus.ax_ready) void'(axq.pop_front());
      exp_done = 1'b0;
      if (bus.rsp_valid) begin
        t_pop = tq.pop_front();
        if (t_pop.fin) begin
          exp_done    = 1'b1;
          exp_done_id = t_pop.id;
        end
      end
      if (bus.meta_valid && exp_mr) begin
        model_txn(r_base, r_num, r_cnt, r_ltn, ax_new.addr, ax_new.len);
        ax_new.wr = !r_ld;
        axq.push_back(ax_new);
        tq.push_back('{fin: (r_rg == 0) && (r_rs == 0) && (r_cnt == r_num), id: r_id});
        accepted++;
      end
    end
    bus.meta_valid = 1'b0;
    bus.rsp_valid  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
